// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, register map,
// status bit positions and the oversample divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_rx_state_t;

  localparam logic UART_REG_DATA   = 1'b0;
  localparam logic UART_REG_STATUS = 1'b1;

  localparam int STAT_FRAMING_BIT = 8;
  localparam int STAT_OVERRUN_BIT = 9;
  localparam int STAT_BUSY_BIT    = 10;
  localparam int DATA_VALID_BIT   = 31;

  // Clocks per 16x oversample tick, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + 8 * baud) / (16 * baud);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; a push into a full FIFO is
// only accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_avalon.sv
// 8N1 UART receiver with a receive FIFO behind a two-register Avalon-MM slave.
//   state    | meaning
//   ST_IDLE  | waiting for a falling edge on the synchronized line
//   ST_START | counting to mid start bit, rejecting glitches
//   ST_DATA  | sampling eight data bits LSB first
//   ST_STOP  | sampling stop bit, then push byte or flag framing error
module uart_rx_avalon
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  input  logic        avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata
);

  localparam int DIV = int'(uart_div(CLK_HZ, BAUD));
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(DIV - 1);

  logic rxd_meta, rxd_sync, rxd_prev, fall;
  uart_rx_state_t state, state_next;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    tick_num;
  logic [2:0]    bit_num;
  logic [7:0]    shreg;
  logic          restart, sample_data, stop_ok, stop_bad;
  logic          push_q, framing, overrun;
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [AW:0]   fifo_count;
  logic          wr_status;
  logic [31:0]   status_word;
  logic          unused_wdata;

  assign unused_wdata = ^{avs_writedata[31:10], avs_writedata[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign fall = rxd_prev && !rxd_sync;
  assign tick = (tick_cnt == '0);

  // Down-counter restarted on frame start so START timing is phase-locked to the edge.
  always_ff @(posedge clk) begin
    if (reset)        tick_cnt <= '0;
    else if (restart) tick_cnt <= TICK_RELOAD;
    else if (tick)    tick_cnt <= TICK_RELOAD;
    else              tick_cnt <= tick_cnt - TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    restart     = 1'b0;
    sample_data = 1'b0;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_next = ST_START;
          restart    = 1'b1;
        end
      end
      ST_START: begin
        if (tick && tick_num == 4'd7) state_next = rxd_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick && tick_num == 4'd15) begin
          sample_data = 1'b1;
          if (bit_num == 3'd7) state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && tick_num == 4'd15) begin
          state_next = ST_IDLE;
          stop_ok    = rxd_sync;
          stop_bad   = !rxd_sync;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Tick index restarts on every state change; inside DATA it wraps each bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_num <= '0;
      bit_num  <= '0;
      shreg    <= '0;
      push_q   <= 1'b0;
    end else begin
      if (restart || state_next != state) tick_num <= '0;
      else if (tick)                      tick_num <= tick_num + 4'd1;
      if (state != ST_DATA)  bit_num <= '0;
      else if (sample_data)  bit_num <= bit_num + 3'd1;
      if (sample_data) shreg <= {rxd_sync, shreg[7:1]};
      push_q <= stop_ok;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .wdata (shreg),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fifo_pop  = avs_read && (avs_address == UART_REG_DATA) && !fifo_empty;
  assign wr_status = avs_write && !avs_read && (avs_address == UART_REG_STATUS);

  always_comb begin
    status_word                   = '0;
    status_word[7:0]              = 8'(fifo_count);
    status_word[STAT_FRAMING_BIT] = framing;
    status_word[STAT_OVERRUN_BIT] = overrun;
    status_word[STAT_BUSY_BIT]    = (state != ST_IDLE);
  end

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      framing      <= 1'b0;
      overrun      <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (stop_bad)                                           framing <= 1'b1;
      else if (wr_status && avs_writedata[STAT_FRAMING_BIT])  framing <= 1'b0;
      if (push_q && fifo_full && !fifo_pop)                   overrun <= 1'b1;
      else if (wr_status && avs_writedata[STAT_OVERRUN_BIT])  overrun <= 1'b0;
      if (avs_read) begin
        if (avs_address == UART_REG_STATUS) begin
          avs_readdata <= status_word;
        end else if (fifo_empty) begin
          avs_readdata <= '0;
        end else begin
          avs_readdata                 <= {24'd0, fifo_head};
          avs_readdata[DATA_VALID_BIT] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_avalon.sv
// Directed bench for uart_rx_avalon at default parameters (432 clocks per bit).
module tb_uart_rx_avalon;

  localparam int BIT_CLKS = 432;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxd;
  logic        avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  uart_rx_avalon dut (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata)
  );

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(BIT_CLKS);
    end
    rxd = stop_bit;
    wait_clks(BIT_CLKS);
    rxd = 1'b1;
  endtask

  task automatic do_read(input logic addr, output logic [31:0] data);
    avs_address = addr;
    avs_read    = 1'b1;
    @(posedge clk);
    #1 data = avs_readdata;
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  task automatic do_write(input logic addr, input logic [31:0] wdata);
    avs_address   = addr;
    avs_write     = 1'b1;
    avs_writedata = wdata;
    @(negedge clk);
    avs_write     = 1'b0;
    avs_writedata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; rxd = 1'b1; avs_address = 1'b0;
    avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    wait_clks(5);
    reset = 1'b0;
    wait_clks(2);
    checks++;
    if (avs_readdata !== 32'h0) begin
      failures++; $display("FAIL reset_readdata got=%h exp=%h", avs_readdata, 32'h0);
    end
    do_read(1'b1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0);
    end
    do_read(1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_single_byte();
    logic [31:0] d;
    send_frame(8'hA5, 1'b1);
    wait_clks(2);
    do_read(1'b0, d);
    checks++;
    if (d !== 32'h800000A5) begin
      failures++; $display("FAIL byte_a5 got=%h exp=%h", d, 32'h800000A5);
    end
    wait_clks(3);
    checks++;
    if (avs_readdata !== 32'h800000A5) begin
      failures++; $display("FAIL readdata_hold got=%h exp=%h", avs_readdata, 32'h800000A5);
    end
    do_read(1'b1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL status_after_a5 got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_framing();
    logic [31:0] d;
    send_frame(8'h55, 1'b0);
    wait_clks(2);
    do_read(1'b1, d);
    checks++;
    if (d !== 32'h100) begin
      failures++; $display("FAIL framing_set got=%h exp=%h", d, 32'h100);
    end
    // read and write together: the clear must be ignored
    avs_address = 1'b1; avs_read = 1'b1; avs_write = 1'b1; avs_writedata = 32'h100;
    @(posedge clk);
    #1 d = avs_readdata;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    checks++;
    if (d !== 32'h100) begin
      failures++; $display("FAIL rw_collision_read got=%h exp=%h", d, 32'h100);
    end
    do_read(1'b1, d);
    checks++;
    if (d !== 32'h100) begin
      failures++; $display("FAIL rw_collision_kept got=%h exp=%h", d, 32'h100);
    end
    do_write(1'b1, 32'h100);
    do_read(1'b1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL framing_clear got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic [31:0] exp;
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b1);
    wait_clks(2);
    do_read(1'b1, d);
    checks++;
    if (d !== 32'h208) begin
      failures++; $display("FAIL overrun_status got=%h exp=%h", d, 32'h208);
    end
    avs_address = 1'b0;
    avs_read    = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      exp = (i < 8) ? (32'h80000000 | 32'(i + 1)) : 32'h0;
      checks++;
      if (avs_readdata !== exp) begin
        failures++; $display("FAIL b2b_read%0d got=%h exp=%h", i, avs_readdata, exp);
      end
    end
    @(negedge clk);
    avs_read = 1'b0;
    do_read(1'b1, d);
    checks++;
    if (d !== 32'h200) begin
      failures++; $display("FAIL drained_status got=%h exp=%h", d, 32'h200);
    end
    do_write(1'b1, 32'h200);
    do_read(1'b1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL overrun_clear got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    rxd = 1'b0;
    wait_clks(50);
    do_read(1'b1, d);
    checks++;
    if (d !== 32'h400) begin
      failures++; $display("FAIL glitch_busy got=%h exp=%h", d, 32'h400);
    end
    wait_clks(49);
    rxd = 1'b1;
    wait_clks(300);
    do_read(1'b1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL glitch_idle got=%h exp=%h", d, 32'h0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic [7:0]  b;
    b   = 8'h3C;
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      wait_clks(BIT_CLKS);
    end
    rxd = b[4];
    wait_clks(BIT_CLKS / 2);
    reset = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    rxd   = 1'b1;
    wait_clks(2 * BIT_CLKS);
    do_read(1'b1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL midframe_reset_status got=%h exp=%h", d, 32'h0);
    end
    send_frame(8'h7E, 1'b1);
    wait_clks(2);
    do_read(1'b0, d);
    checks++;
    if (d !== 32'h8000007E) begin
      failures++; $display("FAIL after_reset_7e got=%h exp=%h", d, 32'h8000007E);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_framing();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
